wbp_memslave: RTL and testbench



---
 rtl/wbp_memslave.sv | 138 +++++++++++++
 tb/tb_wbp_memslave.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbp_memslave.sv
// wbp_memslave: pipelined Wishbone memory slave with byte-lane writes, fixed
// ack latency, out-of-range error responses and optional periodic refresh
// stalls that exercise the master's stall/backpressure handling.
module wbp_memslave #(
  parameter int AW               = 26,
  parameter int DW               = 32,
  parameter int LGMEMSZ          = 10,
  parameter int ACK_LATENCY      = 2,
  parameter int REFRESH_INTERVAL = 0,
  parameter int REFRESH_CYCLES   = 2
) (
  input  logic            S_AXI_ACLK,
  input  logic            S_AXI_ARESETN,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [DW-1:0]   i_wb_data,
  input  logic [DW/8-1:0] i_wb_sel,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic [DW-1:0]   o_wb_data,
  output logic            o_wb_err
);

  localparam int SW     = DW / 8;
  localparam int CNTMAX = (REFRESH_INTERVAL > REFRESH_CYCLES) ? REFRESH_INTERVAL : REFRESH_CYCLES;
  localparam int CW     = (CNTMAX < 2) ? 1 : $clog2(CNTMAX);

  // one completion-pipeline stage
  typedef struct packed {
    logic          vld;
    logic          err;
    logic          we;
    logic [DW-1:0] rdata;
  } stage_t;

  typedef enum logic {ST_IDLE, ST_REFRESH} state_t;

  logic [DW-1:0] mem [0:(1<<LGMEMSZ)-1];

  stage_t [ACK_LATENCY-1:0] pipe_q, pipe_d;
  stage_t                   last;
  logic   [DW-1:0]          data_q, data_d;
  state_t                   state_q, state_d;
  logic   [CW-1:0]          cnt_q, cnt_d;

  logic               accept, bad, rd_hit;
  logic [LGMEMSZ-1:0] idx;

  assign idx = i_wb_addr[LGMEMSZ-1:0];

  // any address bit above the RAM depth marks the request as an error
  generate
    if (LGMEMSZ < AW) begin : g_addr_chk
      assign bad = |i_wb_addr[AW-1:LGMEMSZ];
    end else begin : g_addr_full
      assign bad = 1'b0;
    end
  endgenerate

  // stall comes straight from the state register, so it is glitch-free
  assign o_wb_stall = (state_q == ST_REFRESH);
  assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;

  // refresh scheduler: count idle cycles, then stall for a fixed window
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (REFRESH_INTERVAL > 0) begin
      case (state_q)
        ST_IDLE:
          if (cnt_q == CW'(REFRESH_INTERVAL - 1)) begin
            state_d = ST_REFRESH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        ST_REFRESH:
          if (cnt_q == CW'(REFRESH_CYCLES - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
      endcase
    end
  end

  // completion pipeline: shift by one each cycle, flush on bus abort
  always_comb begin
    pipe_d = pipe_q;
    for (int k = ACK_LATENCY - 1; k > 0; k--) pipe_d[k] = pipe_q[k-1];
    pipe_d[0].vld   = accept;
    pipe_d[0].err   = bad;
    pipe_d[0].we    = i_wb_we;
    pipe_d[0].rdata = mem[idx];
    if (!i_wb_cyc) begin
      for (int k = 0; k < ACK_LATENCY; k++) pipe_d[k].vld = 1'b0;
    end
  end

  assign last = pipe_q[ACK_LATENCY-1];

  // responses are masked the same cycle cyc drops; read data otherwise holds
  always_comb begin
    o_wb_ack  = last.vld & ~last.err & i_wb_cyc;
    o_wb_err  = last.vld &  last.err & i_wb_cyc;
    rd_hit    = o_wb_ack & ~last.we;
    data_d    = rd_hit ? last.rdata : data_q;
    o_wb_data = data_d;
  end

  // control state, cleared asynchronously
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      pipe_q  <= '0;
      data_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      pipe_q  <= pipe_d;
      data_q  <= data_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM byte-lane write on the accept edge; contents survive reset
  always_ff @(posedge S_AXI_ACLK) begin
    if (accept && i_wb_we && !bad) begin
      for (int k = 0; k < SW; k++) begin
        if (i_wb_sel[k]) mem[idx][8*k +: 8] <= i_wb_data[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wbp_memslave.sv
// tb_wbp_memslave: directed bench. Slave A (latency 2, no refresh) is checked
// every cycle against a queue/array model; slave B (latency 1, refresh 8/2)
// is checked for stall cadence, ack timing and accept/ack balance.
module tb_wbp_memslave;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_cyc = 0, a_stb = 0, a_we = 0;
  logic [25:0] a_addr = '0;
  logic [31:0] a_dat = '0;
  logic [3:0]  a_sel = '0;
  logic        a_stall, a_ack, a_err;
  logic [31:0] a_data;

  logic        b_cyc = 0, b_stb = 0, b_we = 0;
  logic [25:0] b_addr = '0;
  logic [31:0] b_dat = '0;
  logic [3:0]  b_sel = '0;
  logic        b_stall, b_ack, b_err;
  logic [31:0] b_data;

  wbp_memslave #(.AW(26), .DW(32), .LGMEMSZ(10), .ACK_LATENCY(2),
                 .REFRESH_INTERVAL(0), .REFRESH_CYCLES(2)) dut_a (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .i_wb_cyc(a_cyc), .i_wb_stb(a_stb), .i_wb_we(a_we), .i_wb_addr(a_addr),
    .i_wb_data(a_dat), .i_wb_sel(a_sel),
    .o_wb_stall(a_stall), .o_wb_ack(a_ack), .o_wb_data(a_data), .o_wb_err(a_err));

  wbp_memslave #(.AW(26), .DW(32), .LGMEMSZ(10), .ACK_LATENCY(1),
                 .REFRESH_INTERVAL(8), .REFRESH_CYCLES(2)) dut_b (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .i_wb_cyc(b_cyc), .i_wb_stb(b_stb), .i_wb_we(b_we), .i_wb_addr(b_addr),
    .i_wb_data(b_dat), .i_wb_sel(b_sel),
    .o_wb_stall(b_stall), .o_wb_ack(b_ack), .o_wb_data(b_data), .o_wb_err(b_err));

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // edges since reset release
  int ecnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    bit          err;
    bit          we;
    logic [31:0] d;
  } item_t;

  item_t       q[$];
  item_t       it;
  logic [31:0] mm [1024];
  logic [31:0] last_rd = '0;
  logic [31:0] exp_d;
  bit          exp_ack, exp_err, exp_bst, b_pend = 0, b_ack_in_stall = 0;
  int          a_ack_cnt = 0, b_ack_cnt = 0, b_acc_cnt = 0;

  initial for (int i = 0; i < 1024; i++) mm[i] = '0;

  // single compare process: outputs of this cycle, then the coming edge's accept
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      last_rd = '0;
      b_pend  = 0;
      chk1("rst_a_ack", a_ack, 1'b0);
      chk1("rst_a_err", a_err, 1'b0);
      chk1("rst_a_stall", a_stall, 1'b0);
      chk32("rst_a_data", a_data, 32'h0);
      chk1("rst_b_ack", b_ack, 1'b0);
      chk1("rst_b_stall", b_stall, 1'b0);
    end else begin
      exp_ack = 0; exp_err = 0; exp_d = last_rd;
      if (!a_cyc) q.delete();
      else if (q.size() > 0 && q[0].due == ecnt) begin
        it = q.pop_front();
        exp_ack = !it.err;
        exp_err = it.err;
        if (!it.err && !it.we) begin exp_d = it.d; last_rd = it.d; end
      end
      chk1("a_ack", a_ack, exp_ack);
      chk1("a_err", a_err, exp_err);
      chk32("a_data", a_data, exp_d);
      chk1("a_stall", a_stall, 1'b0);
      if (a_ack) a_ack_cnt++;
      if (a_cyc && a_stb) begin
        it.due = ecnt + 2;
        it.err = (a_addr[25:10] != 0);
        it.we  = a_we;
        if (!it.err && a_we)
          for (int k = 0; k < 4; k++)
            if (a_sel[k]) mm[a_addr[9:0]][8*k +: 8] = a_dat[8*k +: 8];
        it.d = mm[a_addr[9:0]];
        q.push_back(it);
      end

      exp_bst = (ecnt % 10) >= 8;
      chk1("b_stall", b_stall, exp_bst);
      chk1("b_ack", b_ack, b_pend && b_cyc);
      chk1("b_err", b_err, 1'b0);
      chk32("b_data", b_data, 32'h0);
      if (b_ack) b_ack_cnt++;
      if (b_ack && b_stall) b_ack_in_stall = 1;
      b_pend = b_cyc && b_stb && !exp_bst;
      if (b_pend) b_acc_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  // present one request for one edge; caller is #1 after a posedge
  task automatic a_go(input logic we, input logic [25:0] addr,
                      input logic [31:0] d, input logic [3:0] sel);
    a_cyc = 1; a_stb = 1; a_we = we; a_addr = addr; a_dat = d; a_sel = sel;
    @(posedge clk); #1;
    a_stb = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // wait (bounded) for the response of the request just accepted
  task automatic a_wait_done(input string nm, input logic exp_err,
                             input logic [31:0] exp_d, input bit chk_d);
    int k = 0;
    bit got = 0;
    while (!got && k < 8) begin
      @(negedge clk);
      k++;
      got = a_ack | a_err;
    end
    chk1({nm, "_done"}, got, 1'b1);
    chki({nm, "_lat"}, k, 2);
    chk1({nm, "_err"}, a_err, exp_err);
    if (chk_d) chk32({nm, "_data"}, a_data, exp_d);
    @(posedge clk); #1;
  endtask

  int snap, st, ac;

  initial begin
    #1 rst_n = 0;
    #2;
    chk1("init_ack", a_ack, 1'b0);
    chk1("init_err", a_err, 1'b0);
    chk1("init_stall", a_stall, 1'b0);
    chk32("init_data", a_data, 32'h0);
    @(negedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    a_cyc = 1;

    // write / read back
    a_go(1, 26'd0, 32'hCAFEF00D, 4'hF); a_wait_done("wr0", 1'b0, 32'h0, 0);
    a_go(1, 26'd5, 32'hDEADBEEF, 4'hF); a_wait_done("wr5", 1'b0, 32'h0, 0);
    a_go(0, 26'd5, 32'h0, 4'h0);        a_wait_done("rd5", 1'b0, 32'hDEADBEEF, 1);

    // byte lanes, back-to-back, then read-after-write with no gap
    a_go(1, 26'd7, 32'h11223344, 4'hF);
    a_go(1, 26'd7, 32'hAABBCCDD, 4'b0101);
    a_go(1, 26'd8, 32'h87654321, 4'hF);
    a_go(0, 26'd8, 32'h0, 4'h0);
    idle(4);
    a_go(0, 26'd7, 32'h0, 4'h0);        a_wait_done("rd7", 1'b0, 32'h11BB33DD, 1);

    // out-of-range address
    a_go(1, 26'd1024, 32'h55555555, 4'hF); a_wait_done("wr_bad", 1'b1, 32'h0, 0);
    a_go(0, 26'd1024, 32'h0, 4'h0);        a_wait_done("rd_bad", 1'b1, 32'h0, 0);
    a_go(0, 26'd0, 32'h0, 4'h0);           a_wait_done("rd0", 1'b0, 32'hCAFEF00D, 1);

    // sel=0 write acks and changes nothing
    a_go(1, 26'd5, 32'h0, 4'h0); a_wait_done("wr_sel0", 1'b0, 32'h0, 0);
    a_go(0, 26'd5, 32'h0, 4'h0); a_wait_done("rd5b", 1'b0, 32'hDEADBEEF, 1);

    // abort: four writes, cyc dropped in the cycle after the last accept
    snap = a_ack_cnt;
    for (int i = 0; i < 4; i++) a_go(1, 26'(10 + i), 32'h1000_0000 + 32'(i), 4'hF);
    a_cyc = 0;
    idle(1);
    a_cyc = 1;
    idle(4);
    chki("abort_acks", a_ack_cnt - snap, 2);
    for (int i = 0; i < 4; i++) begin
      a_go(0, 26'(10 + i), 32'h0, 4'h0);
      a_wait_done("rd_abort", 1'b0, 32'h1000_0000 + 32'(i), 1);
    end

    // async reset with two writes in flight
    a_go(1, 26'd30, 32'h0BADCAFE, 4'hF); a_wait_done("wr30", 1'b0, 32'h0, 0);
    a_go(1, 26'd20, 32'h20202020, 4'hF);
    a_go(1, 26'd21, 32'h21212121, 4'hF);
    chk1("inflight_ack", a_ack, 1'b1);
    #1 rst_n = 0;
    #1;
    chk1("arst_ack", a_ack, 1'b0);
    chk1("arst_err", a_err, 1'b0);
    chk1("arst_stall", a_stall, 1'b0);
    @(negedge clk); @(negedge clk); #2 rst_n = 1;
    snap = a_ack_cnt;
    @(posedge clk); #1;
    idle(4);
    chki("post_rst_acks", a_ack_cnt - snap, 0);
    a_go(0, 26'd30, 32'h0, 4'h0); a_wait_done("rd30", 1'b0, 32'h0BADCAFE, 1);

    // refresh slave: continuous strobe for 40 cycles
    a_cyc = 0;
    b_cyc = 1; b_we = 1; b_addr = 26'd3; b_dat = 32'h0303_0303; b_sel = 4'hF; b_stb = 1;
    st = 0; ac = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b_stall) st++;
      else         ac++;
    end
    @(posedge clk); #1;
    b_stb = 0;
    idle(3);
    chki("b_stall_cycles", st, 8);
    chki("b_accepts", ac, 32);
    chki("b_acc_vs_ack", b_ack_cnt, b_acc_cnt);
    chk1("b_ack_in_stall", b_ack_in_stall, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

endmodule
